// File: rtl/alu_pipe_lanes_pkg.sv
// Shared types for the multi-lane pipelined ALU: opcode encoding and the
// stage-1 control payload.
package alu_pipe_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_ACC = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef struct packed {
        op_e  op;
        logic chain;
    } s1_ctrl_t;

    // Only the carry-based ops can span lanes; everything else ignores chain.
    function automatic logic chainable(op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ACC);
    endfunction

endpackage

// File: rtl/alu_pipe_lanes_if.sv
// Operation/result handshake bundle between the operand sequencer (master)
// and the lane ALU (slave).
interface alu_pipe_lanes_if #(
    parameter int WIDTH = 4,
    parameter int N_ALU = 4
);
    logic                       enable;
    logic                       chain;
    logic                       in_valid;
    logic                       in_ready;
    logic [WIDTH*N_ALU-1:0]     a;
    logic [WIDTH*N_ALU-1:0]     b;
    logic [2:0]                 select;
    logic                       acc_clr;
    logic                       out_valid;
    logic                       out_ready;
    logic [2*WIDTH*N_ALU-1:0]   out;
    logic [N_ALU-1:0]           carry_out;
    logic [N_ALU-1:0]           a_greater;
    logic [N_ALU-1:0]           a_equal;
    logic [N_ALU-1:0]           a_less;

    modport master (
        output enable, chain, in_valid, a, b, select, acc_clr, out_ready,
        input  in_ready, out_valid, out, carry_out, a_greater, a_equal, a_less
    );

    modport slave (
        input  enable, chain, in_valid, a, b, select, acc_clr, out_ready,
        output in_ready, out_valid, out, carry_out, a_greater, a_equal, a_less
    );
endinterface

// File: rtl/alu_pipe_lanes_lane.sv
// Combinational single-lane datapath. One shared adder serves add, |a-b|
// and accumulate; cin/cout let the top cascade lanes into a wide adder.
module alu_lane
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e                  op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     acc,
    input  logic                 chain,
    input  logic                 chain_lt,
    input  logic                 cin,
    output logic [2*WIDTH-1:0]   res,
    output logic                 cout,
    output logic                 gt,
    output logic                 eq,
    output logic                 lt
);
    logic             swap;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] sum;

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

    // |a-b| is formed as larger + ~smaller + 1; in chained mode every lane
    // must agree on which operand is larger, so the full-vector compare wins.
    assign swap = chain ? chain_lt : lt;

    always_comb begin
        x = '0;
        y = '0;
        case (op)
            OP_ADD: begin
                x = a;
                y = b;
            end
            OP_SUB: begin
                x = swap ? b : a;
                y = ~(swap ? a : b);
            end
            OP_ACC: begin
                x = acc;
                y = a;
            end
            default: ;
        endcase
        {cout, sum} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

        res = '0;
        case (op)
            OP_ADD, OP_SUB, OP_ACC: res = {{WIDTH{1'b0}}, sum};
            OP_MUL:                 res = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
            OP_AND:                 res = {{WIDTH{1'b0}}, a & b};
            OP_OR:                  res = {{WIDTH{1'b0}}, a | b};
            OP_XOR:                 res = {{WIDTH{1'b0}}, a ^ b};
            default:                res = '0;
        endcase
    end
endmodule

// File: rtl/alu_pipe_lanes.sv
// Two-stage valid/ready pipelined multi-lane ALU with optional lane chaining,
// per-lane multiply and a shared accumulator.
module alu_pipe_lanes
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N_ALU = 4
) (
    input  logic            clk,
    input  logic            arst,
    alu_pipe_lanes_if.slave bus
);
    localparam int VW = WIDTH * N_ALU;

    logic                 run_q;
    logic                 adv1;
    logic                 adv2;
    logic                 vld_p1;
    logic                 vld_p2;
    s1_ctrl_t             ctrl_p1;
    logic [VW-1:0]        a_p1;
    logic [VW-1:0]        b_p1;
    logic [VW-1:0]        acc_q;
    logic [VW-1:0]        acc_base;
    logic                 chain_eff;
    logic                 sub_cin;
    logic                 full_gt;
    logic                 full_eq;
    logic                 full_lt;
    logic [2*VW-1:0]      lane_res;
    logic [VW-1:0]        lane_sum;
    logic [N_ALU-1:0]     lane_cout;
    logic [N_ALU-1:0]     lane_gt;
    logic [N_ALU-1:0]     lane_eq;
    logic [N_ALU-1:0]     lane_lt;
    logic [2*VW-1:0]      out_d;
    logic [N_ALU-1:0]     carry_d;
    logic [N_ALU-1:0]     gt_d;
    logic [N_ALU-1:0]     eq_d;
    logic [N_ALU-1:0]     lt_d;
    logic [2*VW-1:0]      out_p2;
    logic [N_ALU-1:0]     carry_p2;
    logic [N_ALU-1:0]     gt_p2;
    logic [N_ALU-1:0]     eq_p2;
    logic [N_ALU-1:0]     lt_p2;

    // run_q keeps in_ready low until the first edge after reset release.
    assign adv2         = bus.enable && run_q && (!vld_p2 || bus.out_ready);
    assign adv1         = bus.enable && run_q && (!vld_p1 || adv2);
    assign bus.in_ready = adv1;

    // ---- Stage 1: operand capture ----
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            run_q   <= 1'b0;
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else begin
            run_q <= 1'b1;
            if (adv1) begin
                vld_p1 <= bus.in_valid;
                if (bus.in_valid) begin
                    ctrl_p1.op    <= op_e'(bus.select);
                    ctrl_p1.chain <= bus.chain;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv1 && bus.in_valid) begin
            a_p1 <= bus.a;
            b_p1 <= bus.b;
        end
    end

    // ---- Stage 2: compute ----
    assign chain_eff = ctrl_p1.chain && chainable(ctrl_p1.op);
    assign sub_cin   = (ctrl_p1.op == OP_SUB);
    assign full_gt   = (a_p1 > b_p1);
    assign full_eq   = (a_p1 == b_p1);
    assign full_lt   = (a_p1 < b_p1);
    assign acc_base  = bus.acc_clr ? '0 : acc_q;

    for (genvar i = 0; i < N_ALU; i++) begin : g_lane
        logic                cin_g;
        logic                cout_g;
        logic [2*WIDTH-1:0]  res_g;

        if (i == 0) begin : g_first
            assign cin_g = sub_cin;
        end else begin : g_rest
            assign cin_g = chain_eff ? g_lane[i-1].cout_g : sub_cin;
        end

        alu_lane #(.WIDTH(WIDTH)) u_lane (
            .op       (ctrl_p1.op),
            .a        (a_p1[i*WIDTH +: WIDTH]),
            .b        (b_p1[i*WIDTH +: WIDTH]),
            .acc      (acc_base[i*WIDTH +: WIDTH]),
            .chain    (chain_eff),
            .chain_lt (full_lt),
            .cin      (cin_g),
            .res      (res_g),
            .cout     (cout_g),
            .gt       (lane_gt[i]),
            .eq       (lane_eq[i]),
            .lt       (lane_lt[i])
        );

        assign lane_res[i*2*WIDTH +: 2*WIDTH] = res_g;
        assign lane_sum[i*WIDTH +: WIDTH]     = res_g[WIDTH-1:0];
        assign lane_cout[i]                   = cout_g;
    end

    always_comb begin
        out_d   = '0;
        carry_d = '0;
        gt_d    = lane_gt;
        eq_d    = lane_eq;
        lt_d    = lane_lt;
        if (chain_eff) begin
            out_d[VW-1:0]    = lane_sum;
            carry_d[N_ALU-1] = (ctrl_p1.op == OP_SUB) ? full_lt : lane_cout[N_ALU-1];
            gt_d             = {N_ALU{full_gt}};
            eq_d             = {N_ALU{full_eq}};
            lt_d             = {N_ALU{full_lt}};
        end else begin
            out_d = lane_res;
            for (int i = 0; i < N_ALU; i++) begin
                case (ctrl_p1.op)
                    OP_ADD, OP_ACC: carry_d[i] = lane_cout[i];
                    OP_SUB:         carry_d[i] = lane_lt[i];
                    default:        carry_d[i] = 1'b0;
                endcase
            end
        end
    end

    // ---- Stage 2: result and accumulator registers ----
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            vld_p2   <= 1'b0;
            out_p2   <= '0;
            carry_p2 <= '0;
            gt_p2    <= '0;
            eq_p2    <= '0;
            lt_p2    <= '0;
            acc_q    <= '0;
        end else begin
            if (adv2) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    out_p2   <= out_d;
                    carry_p2 <= carry_d;
                    gt_p2    <= gt_d;
                    eq_p2    <= eq_d;
                    lt_p2    <= lt_d;
                end
            end
            // Lane sums already include the cleared base, so clear+acc yields a.
            if (adv2 && vld_p1 && (ctrl_p1.op == OP_ACC)) begin
                acc_q <= lane_sum;
            end else if (bus.enable && run_q && bus.acc_clr) begin
                acc_q <= '0;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out       = out_p2;
    assign bus.carry_out = carry_p2;
    assign bus.a_greater = gt_p2;
    assign bus.a_equal   = eq_p2;
    assign bus.a_less    = lt_p2;
endmodule

// File: tb/tb_alu_pipe_lanes.sv
// Directed bench for alu_pipe_lanes (WIDTH=4, N_ALU=4): vector tables for the
// opcodes and accumulator plus sequences for reset, backpressure and enable.
module tb_alu_pipe_lanes;
    import alu_pipe_pkg::*;

    logic clk;
    logic arst;
    int   checks;
    int   errors;

    alu_pipe_lanes_if #(.WIDTH(4), .N_ALU(4)) bus ();

    alu_pipe_lanes #(.WIDTH(4), .N_ALU(4)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic        chain;
        logic        clr;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_out;
        logic [3:0]  exp_c;
        logic [3:0]  exp_gt;
        logic [3:0]  exp_eq;
        logic [3:0]  exp_lt;
    } vec_t;

    vec_t tbl [14];
    vec_t acc_tbl [7];
    logic [31:0] got_q [$];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] sel, input logic ch, input logic [15:0] a, input logic [15:0] b);
        bus.select   = sel;
        bus.chain    = ch;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
    endtask

    // Issue one op alone, optionally assert acc_clr in the cycle it leaves S1,
    // then check the result two edges after acceptance.
    task automatic run_vec(input vec_t v, input string nm, input int idx);
        chk({nm, "_in_ready"}, idx, bus.in_ready, 1'b1);
        drive_op(v.sel, v.chain, v.a, v.b);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = v.clr;
        @(posedge clk); #1;
        bus.acc_clr  = 1'b0;
        chk({nm, "_valid"}, idx, bus.out_valid, 1'b1);
        chk({nm, "_out"},   idx, bus.out,       v.exp_out);
        chk({nm, "_carry"}, idx, bus.carry_out, v.exp_c);
        chk({nm, "_gt"},    idx, bus.a_greater, v.exp_gt);
        chk({nm, "_eq"},    idx, bus.a_equal,   v.exp_eq);
        chk({nm, "_lt"},    idx, bus.a_less,    v.exp_lt);
    endtask

    initial begin
        logic        took;
        logic [31:0] held;
        checks = 0;
        errors = 0;

        //            sel     ch    clr   a         b         out           c        gt       eq       lt
        tbl[0]  = '{3'b000, 1'b0, 1'b0, 16'h000F, 16'h0001, 32'h00000000, 4'b0001, 4'b0001, 4'b1110, 4'b0000};
        tbl[1]  = '{3'b000, 1'b1, 1'b0, 16'h000F, 16'h0001, 32'h00000010, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[2]  = '{3'b001, 1'b0, 1'b0, 16'h0003, 16'h0007, 32'h00000004, 4'b0001, 4'b0000, 4'b1110, 4'b0001};
        tbl[3]  = '{3'b010, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hE1E1E1E1, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
        tbl[4]  = '{3'b001, 1'b1, 1'b0, 16'h0100, 16'h0001, 32'h000000FF, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        tbl[5]  = '{3'b001, 1'b1, 1'b0, 16'h0001, 16'h0100, 32'h000000FF, 4'b1000, 4'b0000, 4'b0000, 4'b1111};
        tbl[6]  = '{3'b011, 1'b0, 1'b0, 16'hC3A5, 16'h5AF0, 32'h04020A00, 4'b0000, 4'b1001, 4'b0000, 4'b0110};
        tbl[7]  = '{3'b100, 1'b0, 1'b0, 16'hC3A5, 16'h5AF0, 32'h0D0B0F05, 4'b0000, 4'b1001, 4'b0000, 4'b0110};
        tbl[8]  = '{3'b101, 1'b0, 1'b0, 16'hC3A5, 16'h5AF0, 32'h09090505, 4'b0000, 4'b1001, 4'b0000, 4'b0110};
        tbl[9]  = '{3'b111, 1'b0, 1'b0, 16'h1234, 16'h1234, 32'h00000000, 4'b0000, 4'b0000, 4'b1111, 4'b0000};
        tbl[10] = '{3'b000, 1'b0, 1'b0, 16'h9999, 16'h8888, 32'h01010101, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        tbl[11] = '{3'b000, 1'b1, 1'b0, 16'hFFFF, 16'h0001, 32'h00000000, 4'b1000, 4'b1111, 4'b0000, 4'b0000};
        tbl[12] = '{3'b010, 1'b1, 1'b0, 16'h0023, 16'h0045, 32'h0000080F, 4'b0000, 4'b0000, 4'b1100, 4'b0011};
        tbl[13] = '{3'b101, 1'b1, 1'b0, 16'h00FF, 16'h000F, 32'h00000F00, 4'b0000, 4'b0010, 4'b1101, 4'b0000};

        acc_tbl[0] = '{3'b110, 1'b1, 1'b0, 16'h1234, 16'h0000, 32'h00001234, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        acc_tbl[1] = '{3'b110, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 32'h0000FFFF, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        acc_tbl[2] = '{3'b110, 1'b1, 1'b0, 16'h0001, 16'h0000, 32'h00000000, 4'b1000, 4'b1111, 4'b0000, 4'b0000};
        acc_tbl[3] = '{3'b110, 1'b1, 1'b0, 16'h0005, 16'h0000, 32'h00000005, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        acc_tbl[4] = '{3'b110, 1'b1, 1'b1, 16'h0002, 16'h0000, 32'h00000002, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        acc_tbl[5] = '{3'b110, 1'b0, 1'b0, 16'h1111, 16'h0000, 32'h01010103, 4'b0000, 4'b1111, 4'b0000, 4'b0000};
        acc_tbl[6] = '{3'b110, 1'b0, 1'b0, 16'h000F, 16'h0000, 32'h01010102, 4'b0001, 4'b0001, 4'b1110, 4'b0000};

        arst          = 1'b0;
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.chain     = 1'b0;
        bus.select    = 3'b000;
        bus.a         = '0;
        bus.b         = '0;
        bus.acc_clr   = 1'b0;

        // Power-on reset
        #2;
        chk("por_valid", 0, bus.out_valid, 1'b0);
        chk("por_out",   0, bus.out,       32'h0);
        chk("por_ready", 0, bus.in_ready,  1'b0);
        repeat (3) @(posedge clk);
        #1 arst = 1'b1;
        chk("rel_ready_before_edge", 0, bus.in_ready, 1'b0);
        @(posedge clk); #1;
        chk("rel_ready", 0, bus.in_ready, 1'b1);

        // Two ops in flight, then reset drops them
        drive_op(3'b000, 1'b0, 16'h0001, 16'h0002);
        @(posedge clk); #1;
        drive_op(3'b000, 1'b0, 16'h0003, 16'h0004);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        arst = 1'b0;
        #1;
        chk("mid_rst_valid", 0, bus.out_valid, 1'b0);
        chk("mid_rst_out",   0, bus.out,       32'h0);
        chk("mid_rst_carry", 0, bus.carry_out, 4'h0);
        repeat (3) @(posedge clk);
        #1 arst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_ready", 0, bus.in_ready, 1'b1);
        for (int k = 0; k < 2; k++) begin
            chk("no_replay", k, bus.out_valid, 1'b0);
            @(posedge clk); #1;
        end

        // First op after reset: visible exactly two edges after acceptance
        drive_op(3'b000, 1'b0, 16'h0021, 16'h0012);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("lat_1cyc_valid", 0, bus.out_valid, 1'b0);
        @(posedge clk); #1;
        chk("lat_2cyc_valid", 0, bus.out_valid, 1'b1);
        chk("lat_2cyc_out",   0, bus.out,       32'h00000303);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_vec(tbl[i], "vec", i);

        // Accumulator: seed, lone clear pulse, chained accumulation, clear with acc
        @(posedge clk); #1;
        run_vec(acc_tbl[0], "acc", 0);
        bus.acc_clr = 1'b1;
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        for (int i = 1; i < 7; i++) run_vec(acc_tbl[i], "acc", i);

        // Backpressure: two accepted, third blocked, then drained in order
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive_op(3'b000, 1'b0, 16'h0001, 16'h0001);
        @(posedge clk); #1;
        drive_op(3'b000, 1'b0, 16'h0002, 16'h0001);
        chk("bp_ready_op2", 0, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        drive_op(3'b000, 1'b0, 16'h0003, 16'h0001);
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready_blocked", k, bus.in_ready,  1'b0);
            chk("bp_hold_valid",    k, bus.out_valid, 1'b1);
            chk("bp_hold_out",      k, bus.out,       32'h00000002);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        got_q.delete();
        for (int k = 0; k < 6; k++) begin
            #1;
            if (bus.out_valid) got_q.push_back(bus.out);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 0, got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk("bp_order", 0, got_q[0], 32'h00000002);
            chk("bp_order", 1, got_q[1], 32'h00000003);
            chk("bp_order", 2, got_q[2], 32'h00000004);
        end

        // enable low freezes the pipe even with out_ready high
        @(posedge clk); #1;
        drive_op(3'b010, 1'b0, 16'h0007, 16'h0003);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        held = bus.out;
        chk("en_pre_out", 0, held, 32'h00000015);
        bus.enable = 1'b0;
        #1;
        chk("en_low_ready", 0, bus.in_ready, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("en_low_valid", k, bus.out_valid, 1'b1);
            chk("en_low_out",   k, bus.out,       held);
        end
        bus.enable = 1'b1;
        #1;
        chk("en_high_ready", 0, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        chk("en_drain_valid", 0, bus.out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
